// File: rtl/multi_bextdep_pkg.sv
// Shared definitions for the multi-bit-per-cycle bit-extract / bit-deposit unit.
package multi_bextdep_pkg;

  // Operation select carried on din_bdep.
  localparam logic MODE_BEXT = 1'b0;
  localparam logic MODE_BDEP = 1'b1;

  // Control states: waiting for work, consuming mask bits, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, used to size the bit counter so it can hold the value XLEN.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_bextdep_lsb_chain.sv
// Combinational chain that peels off up to NBITS lowest set bits of a mask.
// Each stage isolates the lowest set bit with x & -x, then clears it before
// handing the remainder on to the next stage.
module bextdep_lsb_chain
  import multi_bextdep_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NBITS = 4,
  parameter int CW    = 6
) (
  input  logic [XLEN-1:0]             msk,
  output logic [NBITS-1:0][XLEN-1:0] lsb,
  output logic [XLEN-1:0]             rem,
  output logic [CW-1:0]               used
);

  logic [XLEN-1:0] cur;

  // Walk the stages; a stage whose input is already zero yields a zero one-hot.
  always_comb begin
    cur  = msk;
    used = '0;
    lsb  = '0;
    for (int i = 0; i < NBITS; i++) begin
      lsb[i] = cur & (~cur + XLEN'(1));
      cur    = cur & ~lsb[i];
      if (lsb[i] != '0) used = used + CW'(1);
    end
    rem = cur;
  end

endmodule

// File: rtl/multi_bextdep.sv
// Iterative bext/bdep functional unit processing up to NBITS mask bits per
// cycle, with valid/ready handshakes and a pass-through tag.
module multi_bextdep
  import multi_bextdep_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NBITS = 4,
  parameter int TAGW  = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic            din_bdep,
  input  logic [XLEN-1:0] din_value,
  input  logic [XLEN-1:0] din_mask,
  input  logic [TAGW-1:0] din_tag,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [XLEN-1:0] dout_result,
  output logic [TAGW-1:0] dout_tag
);

  localparam int KW = clog2(XLEN + 1);

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [XLEN-1:0] val_q, val_d;
  logic [XLEN-1:0] msk_q, msk_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [KW-1:0]   k_q, k_d;

  logic [NBITS-1:0][XLEN-1:0] lsb_bits;
  logic [XLEN-1:0]            msk_rem;
  logic [KW-1:0]              used_cnt;
  logic [KW-1:0]              idx;
  logic [XLEN-1:0]            val_shift;
  logic                       accept;

  bextdep_lsb_chain #(
    .XLEN  (XLEN),
    .NBITS (NBITS),
    .CW    (KW)
  ) u_lsb_chain (
    .msk  (msk_q),
    .lsb  (lsb_bits),
    .rem  (msk_rem),
    .used (used_cnt)
  );

  // Handshake outputs come straight from state so din_valid never feeds them.
  assign din_ready   = (state_q == IDLE) || ((state_q == DONE) && dout_ready);
  assign dout_valid  = (state_q == DONE);
  assign dout_result = res_q;
  assign dout_tag    = tag_q;
  assign accept      = din_valid && din_ready;

  // Next-state and datapath update: one batch of mask bits per RUN cycle.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    val_d     = val_q;
    msk_d     = msk_q;
    tag_d     = tag_q;
    res_d     = res_q;
    k_d       = k_q;
    idx       = '0;
    val_shift = '0;

    case (state_q)
      RUN: begin
        for (int i = 0; i < NBITS; i++) begin
          idx       = k_q + KW'(i);
          val_shift = val_q >> idx;
          if (lsb_bits[i] != '0) begin
            if (mode_q == MODE_BDEP) begin
              if (val_shift[0]) res_d = res_d | lsb_bits[i];
            end else begin
              if (|(val_q & lsb_bits[i])) res_d = res_d | (XLEN'(1) << idx);
            end
          end
        end
        msk_d = msk_rem;
        k_d   = k_q + used_cnt;
        if (msk_rem == '0) state_d = DONE;
      end
      DONE: begin
        if (dout_ready) state_d = IDLE;
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (accept) begin
      state_d = RUN;
      mode_d  = din_bdep;
      val_d   = din_value;
      msk_d   = din_mask;
      tag_d   = din_tag;
      res_d   = '0;
      k_d     = '0;
    end
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_BEXT;
      val_q   <= '0;
      msk_q   <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      val_q   <= val_d;
      msk_q   <= msk_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_multi_bextdep.sv
// Directed self-checking bench for multi_bextdep (XLEN=32, NBITS=4, TAGW=4).
module tb_multi_bextdep;

  logic        clock;
  logic        reset;
  logic        din_valid;
  logic        din_ready;
  logic        din_bdep;
  logic [31:0] din_value;
  logic [31:0] din_mask;
  logic [3:0]  din_tag;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_result;
  logic [3:0]  dout_tag;

  int tests;
  int fails;

  multi_bextdep #(
    .XLEN  (32),
    .NBITS (4),
    .TAGW  (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .din_bdep    (din_bdep),
    .din_value   (din_value),
    .din_mask    (din_mask),
    .din_tag     (din_tag),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_result (dout_result),
    .dout_tag    (dout_tag)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One comparison: counts it and reports a failure with observed/expected.
  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
    end
  endtask

  // Present one request, hold it until accepted, then scramble the inputs.
  task automatic applyStimulus(input logic bdep, input logic [31:0] value,
                               input logic [31:0] mask, input logic [3:0] tag);
    int guard;
    guard = 0;
    while (!din_ready && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    if (guard >= 50) checkOutput("din_ready_timeout", {31'd0, din_ready}, 32'd1);
    din_bdep  = bdep;
    din_value = value;
    din_mask  = mask;
    din_tag   = tag;
    din_valid = 1'b1;
    @(posedge clock); #1;
    din_valid = 1'b0;
    din_bdep  = ~bdep;
    din_value = ~value;
    din_mask  = ~mask;
    din_tag   = ~tag;
  endtask

  // Count cycles from the accepting edge until dout_valid, then check result.
  task automatic waitResult(input string name, input logic [31:0] exp_result,
                            input logic [3:0] exp_tag, input int exp_latency);
    int cycles;
    cycles = 0;
    while (!dout_valid && cycles < 100) begin
      @(posedge clock); #1;
      cycles++;
    end
    checkOutput({name, "_latency"}, 32'(cycles), 32'(exp_latency));
    checkOutput({name, "_result"}, dout_result, exp_result);
    checkOutput({name, "_tag"}, {28'd0, dout_tag}, {28'd0, exp_tag});
  endtask

  // Accept the pending result and confirm the unit returns to idle.
  task automatic popResult(input string name);
    dout_ready = 1'b1;
    @(posedge clock); #1;
    dout_ready = 1'b0;
    checkOutput({name, "_valid_drop"}, {31'd0, dout_valid}, 32'd0);
    checkOutput({name, "_ready_idle"}, {31'd0, din_ready}, 32'd1);
  endtask

  // Directed sequence.
  initial begin
    logic [31:0] held_result;
    logic        seen_valid;

    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    din_valid  = 1'b0;
    din_bdep   = 1'b0;
    din_value  = '0;
    din_mask   = '0;
    din_tag    = '0;
    dout_ready = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    checkOutput("rst_din_ready", {31'd0, din_ready}, 32'd1);
    checkOutput("rst_result", dout_result, 32'd0);
    checkOutput("rst_tag", {28'd0, dout_tag}, 32'd0);

    applyStimulus(1'b0, 32'hF0F01234, 32'h0000FF00, 4'd3);
    waitResult("bext_byte", 32'h00000012, 4'd3, 2);
    popResult("bext_byte");

    applyStimulus(1'b1, 32'h000000A5, 32'hF000000F, 4'd6);
    waitResult("bdep_split", 32'hA0000005, 4'd6, 2);
    popResult("bdep_split");

    applyStimulus(1'b0, 32'hFFFFFFFF, 32'h00000000, 4'd1);
    waitResult("bext_zero_mask", 32'h00000000, 4'd1, 1);
    popResult("bext_zero_mask");

    applyStimulus(1'b0, 32'hDEADBEEF, 32'hFFFFFFFF, 4'd2);
    waitResult("bext_full", 32'hDEADBEEF, 4'd2, 8);
    popResult("bext_full");

    applyStimulus(1'b1, 32'hDEADBEEF, 32'hFFFFFFFF, 4'd4);
    waitResult("bdep_full", 32'hDEADBEEF, 4'd4, 8);
    popResult("bdep_full");

    applyStimulus(1'b0, 32'h12345678, 32'h000000FF, 4'd5);
    waitResult("bp_first", 32'h00000078, 4'd5, 2);
    held_result = dout_result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checkOutput("bp_hold_result", dout_result, 32'h00000078);
      checkOutput("bp_hold_tag", {28'd0, dout_tag}, 32'd5);
      checkOutput("bp_hold_din_ready", {31'd0, din_ready}, 32'd0);
      checkOutput("bp_hold_valid", {31'd0, dout_valid}, 32'd1);
    end
    dout_ready = 1'b1;
    din_valid  = 1'b1;
    din_bdep   = 1'b0;
    din_value  = 32'h0000FFFF;
    din_mask   = 32'h000000F0;
    din_tag    = 4'd9;
    #1;
    checkOutput("bp_both_din_ready", {31'd0, din_ready}, 32'd1);
    checkOutput("bp_both_dout_valid", {31'd0, dout_valid}, 32'd1);
    checkOutput("bp_both_result", dout_result, held_result);
    @(posedge clock); #1;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    din_value  = 32'h12340000;
    din_mask   = 32'hFFFF0000;
    checkOutput("bp_next_run_valid", {31'd0, dout_valid}, 32'd0);
    @(posedge clock); #1;
    checkOutput("bp_next_valid", {31'd0, dout_valid}, 32'd1);
    checkOutput("bp_next_result", dout_result, 32'h0000000F);
    checkOutput("bp_next_tag", {28'd0, dout_tag}, 32'd9);
    popResult("bp_next");

    applyStimulus(1'b0, 32'hCAFEF00D, 32'hFFFFFFFF, 4'd7);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("mid_run_valid", {31'd0, dout_valid}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("rst_run_valid", {31'd0, dout_valid}, 32'd0);
    checkOutput("rst_run_din_ready", {31'd0, din_ready}, 32'd1);
    checkOutput("rst_run_result", dout_result, 32'd0);
    checkOutput("rst_run_tag", {28'd0, dout_tag}, 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      seen_valid = seen_valid | dout_valid;
    end
    checkOutput("rst_run_no_result", {31'd0, seen_valid}, 32'd0);

    applyStimulus(1'b0, 32'hDEADBEEF, 32'h0000FFFF, 4'hA);
    waitResult("post_rst", 32'h0000BEEF, 4'hA, 4);
    popResult("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_bextdep.md
Name: multi_bextdep

Overview:
- Iterative bit-extract (bext) / bit-deposit (bdep) unit, parametrised in datapath width and mask bits processed per cycle.
- Generalises the serial single-bit-per-cycle bext/bdep engine; sits beside the ALU as a multi-cycle functional unit.
- Uses a valid/ready handshake on both input and output, and carries a tag through unchanged for out-of-order retirement.
- Latency scales with popcount(mask)/NBITS, not with XLEN.

Parameters:
- XLEN, 32, datapath width; must be ≥ 8 and a power of two.
- NBITS, 4, maximum mask set-bits consumed per cycle; must be in 1..XLEN and divide XLEN.
- TAGW, 4, width of the pass-through tag.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high.
- din_valid  in  1  request valid.
- din_ready  out  1  unit can accept a request.
- din_bdep  in  1  1 = bdep, 0 = bext.
- din_value  in  XLEN  source value.
- din_mask  in  XLEN  mask.
- din_tag  in  TAGW  opaque request tag.
- dout_valid  out  1  result valid.
- dout_ready  in  1  consumer accepts the result.
- dout_result  out  XLEN  result.
- dout_tag  out  TAGW  tag of the returned result.

Behaviour:
- Reset is synchronous, active-high on clock.
  - Reset values: dout_valid=0, din_ready=1, dout_result=0, dout_tag=0.
  - FSM returns to IDLE.
  - Reset mid-operation discards the in-flight request; no dout_valid is produced for it.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: on din_valid&&din_ready, capture bdep/value/mask/tag, clear result c and count k, go to RUN.
  - RUN: each cycle, b_0..b_{NBITS-1} are the NBITS lowest set bits of the remaining mask msk (fewer if fewer bits are set).
    - bext: c[k+i] |= |(val & b_i).
    - bdep: c |= val[k+i] ? b_i : 0.
    - Then clear those b_i from msk and add the number of bits used to k.
    - k is clog2(XLEN+1) bits wide and never exceeds XLEN.
  - RUN → DONE in the cycle where msk becomes zero after the update.
  - A zero mask spends exactly one RUN cycle and yields 0.
  - DONE: dout_valid=1; dout_result and dout_tag held stable until dout_valid&&dout_ready.
- Latency: dout_valid rises max(1, ceil(popcount(mask)/NBITS)) cycles after the accepting edge.
- din_ready = (state==IDLE) || (state==DONE && dout_ready).
  - Simultaneous output handshake and input accept in DONE: the new request goes straight to RUN with no bubble.
- dout_valid and din_ready carry no combinational path from din_valid.
  - din_ready depends combinationally on dout_ready only.
- din_* are sampled only on the accepting edge; changes at other times are ignored.
- Mask bits above XLEN do not exist; all arithmetic is modulo XLEN with no wrap of k.

Decomposition:
- Shared package multi_bextdep_pkg holds:
  - MODE_BEXT/MODE_BDEP constants;
  - state enum IDLE/RUN/DONE;
  - clog2 helper for the k width.
- One combinational sub-module, bextdep_lsb_chain: given msk, outputs NBITS one-hot lowest-set-bit vectors b_i (zero when exhausted), the remaining mask, and a used-count.
  - Implemented as a chain of x & -x stages.

Test Plan (XLEN=32, NBITS=4):
- bext, value=0xF0F01234, mask=0x0000FF00, tag=3 → result 0x00000012, tag 3, dout_valid 2 cycles after accept.
- bdep, value=0x000000A5, mask=0xF000000F → result 0xA0000005, latency 2.
- bext, mask=0x00000000, value=0xFFFFFFFF → result 0x00000000, latency 1.
- bext, mask=0xFFFFFFFF, value=0xDEADBEEF → result 0xDEADBEEF, latency 8. Repeat with bdep: same result, latency 8.
- Back-pressure: hold dout_ready=0 for 5 cycles in DONE → result/tag stable, din_ready=0.
  - Then dout_ready=1 with din_valid=1 (bext 0x0000FFFF/0x000000F0) in the same cycle → both handshakes fire.
  - Next result 0x0000000F arrives 1 cycle later.
- Assert reset for 1 cycle during RUN of a popcount-32 request → dout_valid stays 0, din_ready=1 next cycle.
  - A new request afterwards completes correctly.
